// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, in porch-offset coordinates.
// Overlay/sprite controllers import this for the visible-area bounds.
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned H_ACT_END   = 784;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_ACT_START = 35;
    localparam int unsigned V_ACT_END   = 515;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable and synchronous reset; wrap flags the
// enabled cycle in which the count returns to zero.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, hCount/vCount position, active-low
// syncs and the visible-area flag, all aligned to the same ClkPort edge.
module vga_timing_gen
    import vga_timing_pkg::COORD_W;
#(
    parameter int unsigned CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int unsigned H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int unsigned V_ACT_END   = vga_timing_pkg::V_ACT_END
) (
    input  logic               ClkPort,
    input  logic               rst,
    output logic               pix_en,
    output logic [COORD_W-1:0] hCount,
    output logic [COORD_W-1:0] vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic               frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [COORD_W-1:0] H_SYNC_C  = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] H_ACT_S_C = COORD_W'(H_ACT_START);
    localparam logic [COORD_W-1:0] H_ACT_E_C = COORD_W'(H_ACT_END);
    localparam logic [COORD_W-1:0] V_SYNC_C  = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] V_ACT_S_C = COORD_W'(V_ACT_START);
    localparam logic [COORD_W-1:0] V_ACT_E_C = COORD_W'(V_ACT_END);

    logic [DIV_W-1:0]   div;
    logic               div_wrap;
    logic               h_wrap;
    logic               v_en;
    logic               v_wrap;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;

    mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk   (ClkPort),
        .rst   (rst),
        .en    (1'b1),
        .count (div),
        .wrap  (div_wrap)
    );

    mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_hcnt (
        .clk   (ClkPort),
        .rst   (rst),
        .en    (div_wrap),
        .count (hCount),
        .wrap  (h_wrap)
    );

    assign v_en = h_wrap & div_wrap;

    mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_vcnt (
        .clk   (ClkPort),
        .rst   (rst),
        .en    (v_en),
        .count (vCount),
        .wrap  (v_wrap)
    );

    assign pix_en = (div == DIV_LAST);

    // Decode from the counters' next values so the registered flags move on
    // the same edge as hCount/vCount instead of one pixel late.
    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (div_wrap) h_next = h_wrap ? '0 : hCount + 1'b1;
        if (v_en)     v_next = v_wrap ? '0 : vCount + 1'b1;
    end

    always_ff @(posedge ClkPort) begin
        if (rst) begin
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hSync       <= !(h_next < H_SYNC_C);
            vSync       <= !(v_next < V_SYNC_C);
            bright      <= (h_next >= H_ACT_S_C) && (h_next < H_ACT_E_C) &&
                           (v_next >= V_ACT_S_C) && (v_next < V_ACT_E_C);
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks vga_timing_gen (reduced raster) against an arithmetic model that
// derives every output from the number of clocks since reset release.
module tb_vga_timing_gen;

    localparam int unsigned CD  = 4;
    localparam int unsigned HT  = 40;
    localparam int unsigned HS  = 6;
    localparam int unsigned HAS = 9;
    localparam int unsigned HAE = 33;
    localparam int unsigned VT  = 20;
    localparam int unsigned VS  = 2;
    localparam int unsigned VAS = 4;
    localparam int unsigned VAE = 17;
    localparam int unsigned LINE  = CD * HT;
    localparam int unsigned FRAME = CD * HT * VT;
    localparam int unsigned RH  = 20;
    localparam int unsigned RV  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_start;

    int unsigned n = 0;
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned fs_last = 0;
    int unsigned hs_last = 0;
    bit          fs_valid = 1'b0;
    bit          hs_valid = 1'b0;
    logic        hs_prev = 1'b0;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE)
    ) dut (
        .ClkPort     (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hCount      (hCount),
        .vCount      (vCount),
        .hSync       (hSync),
        .vSync       (vSync),
        .bright      (bright),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned exp_h(input int unsigned cnt);
        return ((cnt / CD) % (HT * VT)) % HT;
    endfunction

    function automatic int unsigned exp_v(input int unsigned cnt);
        return ((cnt / CD) % (HT * VT)) / HT;
    endfunction

    task automatic compare_all();
        int unsigned h, v;
        h = exp_h(n);
        v = exp_v(n);
        check("pix_en", 32'(pix_en), 32'((n % CD) == CD - 1));
        check("hCount", 32'(hCount), h);
        check("vCount", 32'(vCount), v);
        check("hSync", 32'(hSync), 32'(h >= HS));
        check("vSync", 32'(vSync), 32'(v >= VS));
        check("bright", 32'(bright), 32'(h >= HAS && h < HAE && v >= VAS && v < VAE));
        check("frame_start", 32'(frame_start),
              32'((n % CD) == 0 && (n / CD) > 0 && ((n / CD) % (HT * VT)) == 0));
    endtask

    task automatic tick();
        bit rst_edge;
        @(posedge clk);
        cyc++;
        rst_edge = rst;
        if (rst_edge) n = 0; else n++;
        #1;
        compare_all();
        if (rst_edge) begin
            fs_valid = 1'b0;
            hs_valid = 1'b0;
        end else begin
            if (frame_start === 1'b1) begin
                if (fs_valid) check("frame_period", cyc - fs_last, FRAME);
                fs_last  = cyc;
                fs_valid = 1'b1;
            end
            if (hs_prev === 1'b1 && hSync === 1'b0) begin
                if (hs_valid) check("line_period", cyc - hs_last, LINE);
                hs_last  = cyc;
                hs_valid = 1'b1;
            end
        end
        hs_prev = hSync;
    endtask

    task automatic run(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) tick();
    endtask

    task automatic seek_reset(input bit want_pix);
        bit found;
        found = 1'b0;
        for (int unsigned i = 0; i < FRAME + CD && !found; i++) begin
            if (exp_h(n) == RH && exp_v(n) == RV && (((n % CD) == CD - 1) == want_pix))
                found = 1'b1;
            else
                tick();
        end
        check("seek_found", 32'(found), 32'd1);
        check("seek_pix_en", 32'(pix_en), 32'(want_pix));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_h", 32'(hCount), 32'd0);
        check("mid_rst_v", 32'(vCount), 32'd0);
        check("mid_rst_sync", 32'({hSync, vSync, bright, frame_start}), 32'd0);
        run(CD);
        check("mid_rst_repix", 32'(pix_en), 32'd0);
        check("mid_rst_h1", 32'(hCount), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        run(3);
        check("rst_outputs", 32'({pix_en, hSync, vSync, bright, frame_start}), 32'd0);
        check("rst_counts", 32'({hCount, vCount}), 32'd0);
        rst = 1'b0;
        run(3);
        check("first_pix_en", 32'(pix_en), 32'd1);
        run(1);
        check("h_after_first", 32'(hCount), 32'd1);

        run(2 * FRAME + FRAME / 2);

        for (int unsigned k = 0; k < 12; k++) begin
            run($urandom_range(1, 1500));
            rst = 1'b1;
            run($urandom_range(1, 3));
            rst = 1'b0;
        end

        seek_reset(1'b0);
        seek_reset(1'b1);
        run(FRAME + 2 * LINE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
